ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single RAM port (cpu_ram_if) between NREQ cache requesters
//  (icache/dcache of each core).
//  Replaces the point-to-point path in memory_control once a second core's caches are live.
//  Grants one requester at a time and holds the grant until RAM returns ACCESS.
//  Produces per-requester wait signals and the returned load data.
// PARAMETERS
//  NREQ    4   number of requesters (index 0 = highest initial priority)
//  ADDR_W  32  address width
//  DATA_W  32  data word width
// PORTS
//  CLK        in   1            clock, rising edge
//  nRST       in   1            asynchronous active-low reset
//  req_ren    in   NREQ         per-requester read request
//  req_wen    in   NREQ         per-requester write request
//  req_addr   in   NREQ*ADDR_W  per-requester address (slice i)
//  req_store  in   NREQ*DATA_W  per-requester write data (slice i)
//  req_wait   out  NREQ         1 = request not yet complete
//  req_load   out  DATA_W       ramload, broadcast; valid for requester i when req_wait[i]==0
//  ramaddr    out  ADDR_W       RAM address
//  ramstore   out  DATA_W       RAM write data
//  ramREN     out  1            RAM read enable
//  ramWEN     out  1            RAM write enable
//  ramload    in   DATA_W       RAM read data
//  ramstate   in   2            FREE=0, BUSY=1, ACCESS=2, ERROR=3
// BEHAVIOUR
//  Reset (async, nRST=0):
//   - state=IDLE, grant=0, rr_ptr=0.
//   - ramREN=ramWEN=0; ramaddr=ramstore=0.
//   - req_wait = req_ren|req_wen (combinational; no ack possible during reset).
//  Pending request: pend[i] = req_ren[i] | req_wen[i]. If both are set, the access is a write.
//  FSM states:
//   - IDLE: if any pend, pick winner = first pending index at or after rr_ptr (wrapping);
//     latch grant=winner, go to GRANT. If no pend, stay in IDLE.
//   - GRANT: drive ram* from slice[grant].
//     * ramstate==ACCESS: req_wait[grant]=0 this cycle; rr_ptr <= (grant+1) mod NREQ;
//       go to IDLE.
//     * ramstate BUSY/FREE: hold.
//     * ramstate ERROR: hold and retry; no ack.
//     * pend[grant] drops (abort): go to IDLE next cycle, no ack, rr_ptr unchanged.
//  Latency: request at cycle 0 in IDLE -> ram enables at cycle 1 -> earliest ack at cycle 1.
//   A back-to-back request from the same requester re-arbitrates via IDLE
//   (one bubble cycle between accesses).
//  Outputs in GRANT are combinational from the latched grant and live inputs.
//   - The requester must hold addr/store stable until its wait drops.
//  req_wait[i] = pend[i] & ~(state==GRANT & grant==i & ramstate==ACCESS).
//  Non-granted requesters always see wait=1 while pending.
//  Fairness: a requester waits at most NREQ-1 other grants.
//  rr_ptr wraps from NREQ-1 to 0.
//  A mid-operation reset drops ramREN/WEN immediately; the RAM-side transfer is abandoned.
// CONFIGURATION
//  RAM_ARB_WRITE_PRIORITY_EN:
//   - defined: in IDLE, if any req_wen is pending, the winner is chosen round-robin among
//     write requesters only; reads are chosen only when no write is pending.
//   - undefined: pure round-robin, no read/write distinction.
// STRUCTURE
//  Package ram_arb_pkg:
//   - ramstate_t enum (FREE, BUSY, ACCESS, ERROR).
//   - arb_state_t enum (IDLE, GRANT).
//  Sub-module rr_picker #(NREQ): combinational.
//   - Inputs: pend vector, rr_ptr.
//   - Outputs: winner index and a valid bit.
//   - Instantiated once, or twice under RAM_ARB_WRITE_PRIORITY_EN (write mask, all mask).
// TESTING
//  1. Reset with req_ren=4'b0001 held -> ramREN=0 and req_wait=4'b0001 throughout reset.
//     After release: ramREN=1 at next cycle, ramaddr=slice0.
//  2. Single read: req_ren[1]=1, addr=0x40; RAM gives BUSY x2 then ACCESS with ramload=0xDEADBEEF.
//     -> req_wait[1]=0 in the ACCESS cycle only; req_load=0xDEADBEEF.
//  3. All four requesters reading continuously, RAM ACCESS every cycle.
//     -> grant order 0,1,2,3,0; no requester acked twice before the others.
//  4. Req 2 reads while ramstate=ERROR for 3 cycles, then ACCESS.
//     -> ramREN stays 1 throughout; a single ack on the ACCESS cycle.
//  5. Req 0 granted, then drops req_ren before ACCESS.
//     -> ramREN=0 next cycle; state IDLE; rr_ptr still 0.
//  6. With RAM_ARB_WRITE_PRIORITY_EN: req_ren[0]=1 and req_wen[3]=1, rr_ptr=0 -> requester 3
//     granted first with ramWEN=1. Without the macro: requester 0 granted first.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: RAM handshake states and arbiter FSM states.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set bit of pend at or after rr_ptr, wrapping.
module rr_picker #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  pend,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);

  localparam logic [PTR_W:0] NREQ_EXT = (PTR_W + 1)'(NREQ);

  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] idx_s;

  // Scan offsets from farthest to nearest so the nearest pending index is the last one written.
  always_comb begin
    winner = '0;
    valid  = |pend;
    sum_s  = '0;
    idx_s  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum_s = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (sum_s >= NREQ_EXT) begin
        sum_s = sum_s - NREQ_EXT;
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (pend[idx_s]) begin
        winner = idx_s;
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters.
// Optional build macro RAM_ARB_WRITE_PRIORITY_EN: pending writes win arbitration over reads.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_ren,
  input  logic [NREQ-1:0]        req_wen,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_store,
  output logic [NREQ-1:0]        req_wait,
  output logic [DATA_W-1:0]      req_load,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [DATA_W-1:0]      ramstore,
  output logic                   ramREN,
  output logic                   ramWEN,
  input  logic [DATA_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  arb_state_t       state_r, state_nxt_s;
  logic [PTR_W-1:0] grant_r, grant_nxt_s;
  logic [PTR_W-1:0] rr_ptr_r, rr_ptr_nxt_s;

  ramstate_t        ram_st_s;
  logic [NREQ-1:0]  pend_s;
  logic [NREQ-1:0]  hit_s;
  logic [PTR_W-1:0] pick_winner_s;
  logic             pick_valid_s;

  logic [ADDR_W-1:0] addr_arr_s  [NREQ];
  logic [DATA_W-1:0] store_arr_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign addr_arr_s[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign store_arr_s[g] = req_store[g*DATA_W +: DATA_W];
  end

  assign ram_st_s = ramstate_t'(ramstate);
  assign pend_s   = req_ren | req_wen;
  assign req_load = ramload;

`ifdef RAM_ARB_WRITE_PRIORITY_EN
  logic [PTR_W-1:0] wr_winner_s, all_winner_s;
  logic             wr_valid_s, all_valid_s;

  rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_wr (
    .pend   (req_wen),
    .rr_ptr (rr_ptr_r),
    .winner (wr_winner_s),
    .valid  (wr_valid_s)
  );

  rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_all (
    .pend   (pend_s),
    .rr_ptr (rr_ptr_r),
    .winner (all_winner_s),
    .valid  (all_valid_s)
  );

  assign pick_winner_s = wr_valid_s ? wr_winner_s : all_winner_s;
  assign pick_valid_s  = wr_valid_s | all_valid_s;
`else
  rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_all (
    .pend   (pend_s),
    .rr_ptr (rr_ptr_r),
    .winner (pick_winner_s),
    .valid  (pick_valid_s)
  );
`endif

  // Acknowledge only the granted requester, and only while RAM reports ACCESS.
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state_r == GRANT) && (ram_st_s == ACCESS) && (grant_r == PTR_W'(i))) begin
        hit_s[i] = 1'b1;
      end else begin
        hit_s[i] = 1'b0;
      end
    end
  end

  assign req_wait = pend_s & ~hit_s;

  // RAM-side drive follows the granted slice live; a write wins when both enables are set.
  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    if (state_r == GRANT) begin
      ramaddr  = addr_arr_s[grant_r];
      ramstore = store_arr_s[grant_r];
      ramWEN   = req_wen[grant_r];
      ramREN   = req_ren[grant_r] & ~req_wen[grant_r];
    end else begin
      ramaddr  = '0;
      ramstore = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
    end
  end

  // Next-state: arbitrate in IDLE, hold in GRANT until ACCESS or abort.
  always_comb begin
    state_nxt_s  = state_r;
    grant_nxt_s  = grant_r;
    rr_ptr_nxt_s = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          grant_nxt_s = pick_winner_s;
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (!pend_s[grant_r]) begin
          state_nxt_s = IDLE;
        end else if (ram_st_s == ACCESS) begin
          state_nxt_s  = IDLE;
          rr_ptr_nxt_s = (grant_r == LAST_IDX) ? '0 : grant_r + PTR_W'(1);
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= IDLE;
      grant_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      grant_r  <= grant_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

endmodule
